// File: rtl/generador_tono.sv
// Square-wave tone generator for the trumpet voice: codes 2/3/4 play a note, any other code is silence.
// Optional octave-up input enabled by defining GENERADOR_TONO_OCTAVA_EN.
module generador_tono #(
  parameter int HP_WIDTH = 20,
  parameter int HP_COD2  = 47778,
  parameter int HP_COD3  = 37921,
  parameter int HP_COD4  = 31888
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] codigo,
`ifdef GENERADOR_TONO_OCTAVA_EN
  input  logic       octava,
`endif
  output logic       audio_out,
  output logic       nota_activa,
  output logic [2:0] nota_actual
);

  typedef enum logic {
    SILENCIO = 1'b0,
    SONANDO  = 1'b1
  } estado_t;

  estado_t             estado;
  logic [HP_WIDTH-1:0] cnt;
  logic                oct_sel;

`ifdef GENERADOR_TONO_OCTAVA_EN
  assign oct_sel = octava;
`else
  assign oct_sel = 1'b0;
`endif

  function automatic logic es_valido(input logic [2:0] c);
    return (c == 3'd2) || (c == 3'd3) || (c == 3'd4);
  endfunction

  // Counter reload for a half period; octave up halves the half period.
  function automatic logic [HP_WIDTH-1:0] recarga(input logic [2:0] c, input logic oct);
    logic [HP_WIDTH-1:0] hp;
    case (c)
      3'd3:    hp = HP_WIDTH'(HP_COD3);
      3'd4:    hp = HP_WIDTH'(HP_COD4);
      default: hp = HP_WIDTH'(HP_COD2);
    endcase
    if (oct) hp = hp >> 1;
    return hp - HP_WIDTH'(1);
  endfunction

  // NOTE: all state is updated with non-blocking assignments so every branch reads the
  // pre-edge values of cnt, audio_out and nota_actual, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      estado      <= SILENCIO;
      audio_out   <= 1'b0;
      nota_activa <= 1'b0;
      nota_actual <= 3'd0;
      cnt         <= '0;
    end else begin
      case (estado)
        SILENCIO: begin
          audio_out <= 1'b0;
          if (es_valido(codigo)) begin
            estado      <= SONANDO;
            audio_out   <= 1'b1;
            nota_activa <= 1'b1;
            nota_actual <= codigo;
            cnt         <= recarga(codigo, oct_sel);
          end
        end
        SONANDO: begin
          if (cnt != '0) begin
            cnt <= cnt - HP_WIDTH'(1);
          end else if (audio_out) begin
            // The low half always follows a high half, even when silence is requested.
            audio_out <= 1'b0;
            if (es_valido(codigo)) begin
              nota_actual <= codigo;
              cnt         <= recarga(codigo, oct_sel);
            end else begin
              cnt <= recarga(nota_actual, oct_sel);
            end
          end else if (es_valido(codigo)) begin
            audio_out   <= 1'b1;
            nota_actual <= codigo;
            cnt         <= recarga(codigo, oct_sel);
          end else begin
            estado      <= SILENCIO;
            nota_activa <= 1'b0;
            nota_actual <= 3'd0;
          end
        end
        default: estado <= SILENCIO;
      endcase
    end
  end

endmodule

// File: tb/tb_generador_tono.sv
// Self-checking bench for generador_tono: directed scenarios plus randomized code streams
// compared against a half-period-level reference model.
module tb_generador_tono;

  localparam int HP2  = 4;
  localparam int HP3  = 3;
  localparam int HP4  = 2;
  localparam int MAXN = 512;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] codigo;
`ifdef GENERADOR_TONO_OCTAVA_EN
  logic       octava;
`endif
  logic       audio_out;
  logic       nota_activa;
  logic [2:0] nota_actual;

  int checks = 0;
  int errors = 0;

  int cod_q [MAXN];
  bit oct_q [MAXN];
  int nlen;

  bit exp_audio [MAXN];
  bit exp_act   [MAXN];
  int exp_nota  [MAXN];
  bit obs_audio [MAXN];
  bit obs_act   [MAXN];
  int obs_nota  [MAXN];

  generador_tono #(
    .HP_WIDTH(20),
    .HP_COD2 (HP2),
    .HP_COD3 (HP3),
    .HP_COD4 (HP4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .codigo     (codigo),
`ifdef GENERADOR_TONO_OCTAVA_EN
    .octava     (octava),
`endif
    .audio_out  (audio_out),
    .nota_activa(nota_activa),
    .nota_actual(nota_actual)
  );

  always #5 clk = ~clk;

  function automatic bit valido(input int c);
    return (c >= 2) && (c <= 4);
  endfunction

  function automatic int hp_of(input int c, input bit o);
    int h;
    h = (c == 2) ? HP2 : (c == 3) ? HP3 : HP4;
    return o ? (h >> 1) : h;
  endfunction

  task automatic clear_seq();
    nlen = 0;
  endtask

  task automatic add(input int c, input int n, input bit o);
    for (int i = 0; i < n; i++) begin
      if (nlen < MAXN) begin
        cod_q[nlen] = c;
        oct_q[nlen] = o;
        nlen++;
      end
    end
  endtask

  // Walks the stream half period by half period; entry k is the output after the edge that sampled cod_q[k].
  task automatic build_model();
    int  t;
    bit  sil;
    bit  lvl;
    int  nota;
    int  len;
    t = 0; sil = 1'b1; lvl = 1'b0; nota = 0; len = 0;
    while (t < nlen) begin
      if (sil) begin
        if (valido(cod_q[t])) begin
          sil = 1'b0; lvl = 1'b1; nota = cod_q[t]; len = hp_of(nota, oct_q[t]);
        end else begin
          exp_audio[t] = 1'b0; exp_act[t] = 1'b0; exp_nota[t] = 0;
          t++;
          continue;
        end
      end
      for (int j = 0; j < len; j++) begin
        if (t + j < nlen) begin
          exp_audio[t+j] = lvl; exp_act[t+j] = 1'b1; exp_nota[t+j] = nota;
        end
      end
      t += len;
      if (t >= nlen) break;
      if (lvl) begin
        if (valido(cod_q[t])) nota = cod_q[t];
        lvl = 1'b0;
        len = hp_of(nota, oct_q[t]);
      end else if (valido(cod_q[t])) begin
        lvl = 1'b1;
        nota = cod_q[t];
        len = hp_of(nota, oct_q[t]);
      end else begin
        sil = 1'b1;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    codigo = 3'd0;
`ifdef GENERADOR_TONO_OCTAVA_EN
    octava = 1'b0;
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic run_and_check(input string name);
    build_model();
    for (int k = 0; k < nlen; k++) begin
      codigo = 3'(cod_q[k]);
`ifdef GENERADOR_TONO_OCTAVA_EN
      octava = oct_q[k];
`endif
      @(posedge clk);
      #1;
      obs_audio[k] = audio_out;
      obs_act[k]   = nota_activa;
      obs_nota[k]  = int'(nota_actual);
      checks++;
      if ({audio_out, nota_activa, nota_actual} !== {exp_audio[k], exp_act[k], 3'(exp_nota[k])}) begin
        errors++;
        $display("FAIL %s cycle %0d: got audio=%b activa=%b nota=%0d, expected audio=%b activa=%b nota=%0d",
                 name, k, audio_out, nota_activa, nota_actual, exp_audio[k], exp_act[k], exp_nota[k]);
      end
    end
  endtask

  task automatic expect_outputs(input string name, input bit a, input bit act, input int nota);
    checks++;
    if ({audio_out, nota_activa, nota_actual} !== {a, act, 3'(nota)}) begin
      errors++;
      $display("FAIL %s: got audio=%b activa=%b nota=%0d, expected audio=%b activa=%b nota=%0d",
               name, audio_out, nota_activa, nota_actual, a, act, nota);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    codigo = 3'd2;
`ifdef GENERADOR_TONO_OCTAVA_EN
    octava = 1'b0;
`endif
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      expect_outputs("reset_hold", 1'b0, 1'b0, 0);
    end
    rst = 1'b0;
    expect_outputs("reset_release", 1'b0, 1'b0, 0);
    @(posedge clk);
    #1;
    expect_outputs("start_after_reset", 1'b1, 1'b1, 2);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    expect_outputs("reset_mid_note", 1'b0, 1'b0, 0);
    codigo = 3'd0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    expect_outputs("no_tail_after_reset", 1'b0, 1'b0, 0);
  endtask

  task automatic test_basic_note();
    do_reset();
    clear_seq();
    add(2, 12, 1'b0);
    run_and_check("basic_note");
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (obs_audio[k] !== (k < 4)) begin
        errors++;
        $display("FAIL basic_note_shape k=%0d: got audio=%b expected %b", k, obs_audio[k], (k < 4));
      end
    end
  endtask

  task automatic test_note_change();
    do_reset();
    clear_seq();
    add(2, 2, 1'b0);
    add(4, 14, 1'b0);
    run_and_check("note_change");
    checks++;
    if (obs_audio[3] !== 1'b1 || obs_nota[3] != 2 || obs_audio[4] !== 1'b0 || obs_nota[4] != 4) begin
      errors++;
      $display("FAIL note_change_boundary: got a3=%b n3=%0d a4=%b n4=%0d, expected a3=1 n3=2 a4=0 n4=4",
               obs_audio[3], obs_nota[3], obs_audio[4], obs_nota[4]);
    end
  endtask

  task automatic test_silence_request();
    do_reset();
    clear_seq();
    add(3, 1, 1'b0);
    add(0, 12, 1'b0);
    run_and_check("silence_request");
    checks++;
    if (obs_act[5] !== 1'b1 || obs_act[6] !== 1'b0 || obs_audio[6] !== 1'b0) begin
      errors++;
      $display("FAIL silence_request_end: got act5=%b act6=%b audio6=%b, expected 1 0 0",
               obs_act[5], obs_act[6], obs_audio[6]);
    end
  endtask

  task automatic test_toggle_between_boundaries();
    do_reset();
    clear_seq();
    for (int p = 0; p < 4; p++) begin
      add(2, 1, 1'b0);
      add(3, 1, 1'b0);
      add(2, 1, 1'b0);
      add(3, 1, 1'b0);
    end
    add(2, 1, 1'b0);
    run_and_check("toggle_between_boundaries");
  endtask

  task automatic test_back_to_back_random();
    for (int r = 0; r < 8; r++) begin
      do_reset();
      clear_seq();
      while (nlen < 120) begin
`ifdef GENERADOR_TONO_OCTAVA_EN
        add(int'($urandom_range(0, 6)), int'($urandom_range(1, 9)), 1'($urandom_range(0, 1)));
`else
        add(int'($urandom_range(0, 6)), int'($urandom_range(1, 9)), 1'b0);
`endif
      end
      run_and_check($sformatf("random_%0d", r));
    end
  endtask

`ifdef GENERADOR_TONO_OCTAVA_EN
  task automatic test_octava();
    do_reset();
    clear_seq();
    add(2, 4, 1'b1);
    add(2, 12, 1'b0);
    run_and_check("octava");
    checks++;
    if (obs_audio[1] !== 1'b1 || obs_audio[2] !== 1'b0 || obs_audio[4] !== 1'b1 || obs_audio[7] !== 1'b1 || obs_audio[8] !== 1'b0) begin
      errors++;
      $display("FAIL octava_shape: got a1=%b a2=%b a4=%b a7=%b a8=%b, expected 1 0 1 1 0",
               obs_audio[1], obs_audio[2], obs_audio[4], obs_audio[7], obs_audio[8]);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    codigo = 3'd0;
    test_reset();
    test_basic_note();
    test_note_change();
    test_silence_request();
    test_toggle_between_boundaries();
`ifdef GENERADOR_TONO_OCTAVA_EN
    test_octava();
`endif
    test_back_to_back_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
